// File: rtl/bf_exec_ctrl_if.sv
// bf_exec_ctrl_if: host command, program load, core control and tx sink signals of the execution sequencer.
interface bf_exec_ctrl_if #(
    parameter int ROM_ADDR_W = 8,
    parameter int DATA_W     = 8,
    parameter int STEP_W     = 16
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [ROM_ADDR_W-1:0] cmd_len;
    logic                  ld_valid;
    logic                  ld_ready;
    logic [2:0]            ld_op;
    logic                  rom_we;
    logic [ROM_ADDR_W-1:0] rom_waddr;
    logic [2:0]            rom_wdata;
    logic                  core_enable;
    logic                  core_restart;
    logic [ROM_ADDR_W-1:0] core_rom_addr;
    logic                  core_cout;
    logic [DATA_W-1:0]     core_val;
    logic                  tx_valid;
    logic [DATA_W-1:0]     tx_data;
    logic                  tx_ready;
    logic                  busy;
    logic                  done;
    logic                  err_timeout;
    logic [STEP_W-1:0]     step_count;
    modport slave (
        input  cmd_valid, cmd_op, cmd_len, ld_valid, ld_op, core_rom_addr, core_cout, core_val, tx_ready,
        output cmd_ready, ld_ready, rom_we, rom_waddr, rom_wdata, core_enable, core_restart,
               tx_valid, tx_data, busy, done, err_timeout, step_count
    );
    modport master (
        output cmd_valid, cmd_op, cmd_len, ld_valid, ld_op, core_rom_addr, core_cout, core_val, tx_ready,
        input  cmd_ready, ld_ready, rom_we, rom_waddr, rom_wdata, core_enable, core_restart,
               tx_valid, tx_data, busy, done, err_timeout, step_count
    );
endinterface

// File: rtl/bf_exec_ctrl.sv
// bf_exec_ctrl: loads the program ROM, single-steps the brainfuck core, drains '.' bytes and enforces a step watchdog.
module bf_exec_ctrl #(
    parameter int ROM_ADDR_W = 8,
    parameter int DATA_W     = 8,
    parameter int STEP_W     = 16,
    parameter int STEP_LIMIT = 0
) (
    input logic         clk,
    input logic         rst,
    bf_exec_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, PAUSED, EXEC, CHECK, TX, DONE} state_e;
    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_RUN  = 2'd1;
    localparam logic [1:0] OP_STEP = 2'd2;
    localparam logic [1:0] OP_HALT = 2'd3;
    localparam logic [STEP_W-1:0] LIMIT = STEP_W'(STEP_LIMIT);
    state_e                state_q, state_d, resume;
    logic [ROM_ADDR_W-1:0] len_q, len_d, wcnt_q, wcnt_d;
    logic                  run_q, run_d, halt_q, halt_d, err_q, err_d;
    logic [STEP_W-1:0]     step_q, step_d;
    logic [DATA_W-1:0]     txd_q, txd_d;
    logic                  cmd_fire, ld_fire, load_fin, at_end, trip, leave;
    assign bus.cmd_ready    = !(state_q inside {LOAD, TX});
    assign cmd_fire         = bus.cmd_valid && bus.cmd_ready;
    assign load_fin         = state_q == LOAD && wcnt_q == len_q;
    assign bus.ld_ready     = state_q == LOAD && !load_fin;
    assign ld_fire          = bus.ld_valid && bus.ld_ready;
    assign bus.rom_we       = ld_fire;
    assign bus.rom_waddr    = wcnt_q;
    assign bus.rom_wdata    = bus.ld_op;
    assign bus.core_enable  = state_q == EXEC;
    assign bus.core_restart = load_fin;
    assign bus.tx_valid     = state_q == TX;
    assign bus.tx_data      = txd_q;
    assign bus.busy         = state_q inside {LOAD, EXEC, CHECK, TX};
    assign bus.done         = state_q == DONE;
    assign bus.err_timeout  = err_q;
    assign bus.step_count   = step_q;
    // Post-instruction decision shared by CHECK without output and by the TX handshake.
    assign at_end = bus.core_rom_addr == len_q;
    assign trip   = !at_end && STEP_LIMIT != 0 && step_q >= LIMIT;
    assign resume = (at_end || trip) ? DONE : (halt_q || !run_q) ? PAUSED : EXEC;
    assign leave  = (state_q == CHECK && !bus.core_cout) || (state_q == TX && bus.tx_ready);
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        wcnt_d  = wcnt_q;
        run_d   = run_q;
        halt_d  = halt_q;
        err_d   = err_q;
        step_d  = step_q;
        txd_d   = txd_q;
        if (cmd_fire && bus.cmd_op == OP_HALT && state_q inside {EXEC, CHECK}) halt_d = 1'b1;
        if (cmd_fire && bus.cmd_op == OP_LOAD && state_q inside {IDLE, PAUSED, DONE}) begin
            state_d = LOAD;
            len_d   = bus.cmd_len;
            wcnt_d  = '0;
            halt_d  = 1'b0;
            err_d   = 1'b0;
        end
        if (cmd_fire && state_q == PAUSED && bus.cmd_op inside {OP_RUN, OP_STEP}) begin
            state_d = EXEC;
            run_d   = bus.cmd_op == OP_RUN;
        end
        if (ld_fire) wcnt_d = wcnt_q + 1'b1;
        if (load_fin) begin
            state_d = PAUSED;
            step_d  = '0;
            err_d   = 1'b0;
        end
        if (state_q == EXEC) begin
            state_d = CHECK;
            step_d  = &step_q ? step_q : step_q + 1'b1;
        end
        if (state_q == CHECK && bus.core_cout) begin
            state_d = TX;
            txd_d   = bus.core_val;
        end
        if (leave) begin
            state_d = resume;
            err_d   = err_q | trip;
            halt_d  = resume == PAUSED ? 1'b0 : halt_d;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            wcnt_q  <= '0;
            run_q   <= 1'b0;
            halt_q  <= 1'b0;
            err_q   <= 1'b0;
            step_q  <= '0;
            txd_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            wcnt_q  <= wcnt_d;
            run_q   <= run_d;
            halt_q  <= halt_d;
            err_q   <= err_d;
            step_q  <= step_d;
            txd_q   <= txd_d;
        end
    end
endmodule

// File: tb/tb_bf_exec_ctrl.sv
// tb_bf_exec_ctrl: drives bf_exec_ctrl against a behavioural brainfuck core and a tx-byte scoreboard.
module tb_bf_exec_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    bf_exec_ctrl_if #(.ROM_ADDR_W(8), .DATA_W(8), .STEP_W(16)) bus ();
    bf_exec_ctrl #(.ROM_ADDR_W(8), .DATA_W(8), .STEP_W(16), .STEP_LIMIT(20)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_restart = 0;
    int rx_rd = 0;
    int en_q[$];
    int wa_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    // Behavioural core: ops 7 '+', 6 '-', 4 '>', 5 '<', 1 '.', 3 '[', 2 ']'.
    logic [2:0] rom [0:255];
    logic [7:0] tape [0:255];
    logic [7:0] pc, dp, cval;
    logic       cout;
    assign bus.core_rom_addr = pc;
    assign bus.core_cout     = cout;
    assign bus.core_val      = cval;
    function automatic logic [7:0] match_fwd(input logic [7:0] p);
        int d = 0;
        for (int i = int'(p); i < 256; i++) begin
            if (rom[i] == 3'd3) d++;
            else if (rom[i] == 3'd2) begin
                d--;
                if (d == 0) return 8'(i);
            end
        end
        return p;
    endfunction
    function automatic logic [7:0] match_back(input logic [7:0] p);
        int d = 0;
        for (int i = int'(p); i >= 0; i--) begin
            if (rom[i] == 3'd2) d++;
            else if (rom[i] == 3'd3) begin
                d--;
                if (d == 0) return 8'(i);
            end
        end
        return p;
    endfunction
    always @(posedge clk) begin
        if (bus.rom_we) rom[bus.rom_waddr] <= bus.rom_wdata;
        if (rst || bus.core_restart) begin
            pc   <= '0;
            dp   <= '0;
            cout <= 1'b0;
            cval <= '0;
            for (int i = 0; i < 256; i++) tape[i] <= '0;
        end else if (bus.core_enable) begin
            cout <= rom[pc] == 3'd1;
            cval <= tape[dp];
            pc   <= pc + 8'd1;
            case (rom[pc])
                3'd7: tape[dp] <= tape[dp] + 8'd1;
                3'd6: tape[dp] <= tape[dp] - 8'd1;
                3'd4: dp <= dp + 8'd1;
                3'd5: dp <= dp - 8'd1;
                3'd3: if (tape[dp] == 8'd0) pc <= match_fwd(pc) + 8'd1;
                3'd2: if (tape[dp] != 8'd0) pc <= match_back(pc) + 8'd1;
                default: ;
            endcase
        end
    end
    always @(negedge clk) begin
        cyc++;
        if (bus.core_enable) en_q.push_back(cyc);
        if (bus.core_restart) n_restart++;
        if (bus.rom_we) wa_q.push_back(int'(bus.rom_waddr));
        if (bus.tx_valid && bus.tx_ready) rx_q.push_back(bus.tx_data);
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic bound_fail(input string what);
        checks++;
        failures++;
        $display("FAIL bound_%s: wait expired, required completion", what);
    endtask
    task automatic send_cmd(input logic [1:0] op, input logic [7:0] len);
        int n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_len   = len;
        while (!bus.cmd_ready && n < 50) begin
            tick();
            n++;
        end
        if (n == 50) bound_fail("cmd_ready");
        tick();
        bus.cmd_valid = 1'b0;
    endtask
    task automatic load_prog(input logic [2:0] p[$]);
        send_cmd(2'd0, 8'(p.size()));
        foreach (p[i]) begin
            int n = 0;
            bus.ld_valid = 1'b1;
            bus.ld_op    = p[i];
            while (!bus.ld_ready && n < 20) begin
                tick();
                n++;
            end
            if (n == 20) bound_fail("ld_ready");
            tick();
        end
        bus.ld_valid = 1'b0;
        tick();
    endtask
    task automatic settle(input int max);
        int n = 0;
        while (bus.busy && n < max) begin
            tick();
            n++;
        end
        if (n == max) bound_fail("settle");
    endtask
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        checks++;
        if ({bus.busy, bus.done, bus.err_timeout, bus.tx_valid, bus.core_enable, bus.core_restart, bus.ld_ready, bus.rom_we} !== 8'd0) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 00000000", {bus.busy, bus.done, bus.err_timeout, bus.tx_valid, bus.core_enable, bus.core_restart, bus.ld_ready, bus.rom_we});
        end
        checks++;
        if (bus.step_count !== 16'd0 || bus.tx_data !== 8'd0) begin
            failures++;
            $display("FAIL reset_regs: step=%0d tx_data=%0h expected 0 and 0", bus.step_count, bus.tx_data);
        end
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_cmd_ready: got %b expected 1", bus.cmd_ready);
        end
    endtask
    task automatic test_run_basic();
        logic [2:0] p[$];
        int w_b = wa_q.size();
        int r_b = n_restart;
        int e_b;
        p = '{3'd7, 3'd7, 3'd1};
        bus.tx_ready = 1'b1;
        load_prog(p);
        checks++;
        if (wa_q.size() - w_b != 3 || wa_q[w_b] != 0 || wa_q[w_b+1] != 1 || wa_q[w_b+2] != 2) begin
            failures++;
            $display("FAIL basic_rom_writes: got %0d writes expected 3 at addrs 0,1,2", wa_q.size() - w_b);
        end
        checks++;
        if (n_restart - r_b != 1) begin
            failures++;
            $display("FAIL basic_restart: got %0d pulses expected 1", n_restart - r_b);
        end
        checks++;
        if ({bus.busy, bus.done, bus.cmd_ready} !== 3'b001) begin
            failures++;
            $display("FAIL basic_paused: busy,done,ready=%b expected 001", {bus.busy, bus.done, bus.cmd_ready});
        end
        exp_q.push_back(8'h02);
        e_b = en_q.size();
        send_cmd(2'd1, 8'd0);
        settle(100);
        checks++;
        if (bus.done !== 1'b1 || bus.step_count !== 16'd3) begin
            failures++;
            $display("FAIL basic_done: done=%b step=%0d expected 1 and 3", bus.done, bus.step_count);
        end
        checks++;
        if (en_q.size() - e_b != 3 || en_q[e_b+1] - en_q[e_b] != 2 || en_q[e_b+2] - en_q[e_b+1] != 2) begin
            failures++;
            $display("FAIL basic_enables: got %0d pulses expected 3 on alternate cycles", en_q.size() - e_b);
        end
        checks++;
        if (rx_q.size() != rx_rd + 1 || rx_q[rx_rd] !== exp_q[0]) begin
            failures++;
            $display("FAIL basic_tx: got %0d bytes first=%0h expected 1 byte %0h", rx_q.size() - rx_rd, rx_q.size() > rx_rd ? rx_q[rx_rd] : 8'hxx, exp_q[0]);
        end
        rx_rd = rx_q.size();
        void'(exp_q.pop_front());
    endtask
    task automatic test_tx_stall();
        logic [2:0] p[$];
        int e_b, n = 0;
        p = '{3'd7, 3'd7, 3'd1};
        bus.tx_ready = 1'b0;
        load_prog(p);
        exp_q.push_back(8'h02);
        send_cmd(2'd1, 8'd0);
        while (!bus.tx_valid && n < 50) begin
            tick();
            n++;
        end
        if (n == 50) bound_fail("tx_valid");
        e_b = en_q.size();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== exp_q[0] || en_q.size() != e_b) begin
                failures++;
                $display("FAIL stall_hold_%0d: valid=%b data=%0h new_enables=%0d expected 1, %0h, 0", i, bus.tx_valid, bus.tx_data, en_q.size() - e_b, exp_q[0]);
            end
            tick();
        end
        bus.tx_ready = 1'b1;
        settle(50);
        checks++;
        if (bus.done !== 1'b1 || bus.step_count !== 16'd3 || en_q.size() != e_b) begin
            failures++;
            $display("FAIL stall_done: done=%b step=%0d new_enables=%0d expected 1, 3, 0", bus.done, bus.step_count, en_q.size() - e_b);
        end
        checks++;
        if (rx_q.size() != rx_rd + 1 || rx_q[rx_rd] !== exp_q[0]) begin
            failures++;
            $display("FAIL stall_tx: got %0d bytes expected exactly one %0h", rx_q.size() - rx_rd, exp_q[0]);
        end
        rx_rd = rx_q.size();
        void'(exp_q.pop_front());
    endtask
    task automatic test_step();
        logic [2:0] p[$];
        int e_b;
        p = '{3'd7, 3'd7, 3'd1};
        load_prog(p);
        e_b = en_q.size();
        for (int k = 1; k <= 2; k++) begin
            send_cmd(2'd2, 8'd0);
            settle(20);
            checks++;
            if (bus.step_count !== 16'(k) || en_q.size() - e_b != k || {bus.busy, bus.done} !== 2'b00) begin
                failures++;
                $display("FAIL step_%0d: step=%0d enables=%0d busy,done=%b expected %0d, %0d, 00", k, bus.step_count, en_q.size() - e_b, {bus.busy, bus.done}, k, k);
            end
        end
        exp_q.push_back(8'h02);
        send_cmd(2'd1, 8'd0);
        settle(50);
        checks++;
        if (bus.done !== 1'b1 || bus.step_count !== 16'd3 || rx_q.size() != rx_rd + 1 || rx_q[rx_rd] !== exp_q[0]) begin
            failures++;
            $display("FAIL step_run: done=%b step=%0d bytes=%0d expected 1, 3, one %0h", bus.done, bus.step_count, rx_q.size() - rx_rd, exp_q[0]);
        end
        rx_rd = rx_q.size();
        void'(exp_q.pop_front());
    endtask
    task automatic test_timeout();
        logic [2:0] p[$];
        int e_b;
        p = '{3'd7, 3'd3, 3'd2};
        load_prog(p);
        e_b = en_q.size();
        send_cmd(2'd1, 8'd0);
        settle(200);
        checks++;
        if (bus.err_timeout !== 1'b1 || bus.done !== 1'b1) begin
            failures++;
            $display("FAIL timeout_flags: err=%b done=%b expected 1 and 1", bus.err_timeout, bus.done);
        end
        checks++;
        if (bus.step_count !== 16'd20 || en_q.size() - e_b != 20) begin
            failures++;
            $display("FAIL timeout_steps: step=%0d enables=%0d expected 20 and 20", bus.step_count, en_q.size() - e_b);
        end
        p = '{3'd7, 3'd7, 3'd1};
        load_prog(p);
        checks++;
        if (bus.err_timeout !== 1'b0 || bus.step_count !== 16'd0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL timeout_clear: err=%b step=%0d done=%b expected 0, 0, 0", bus.err_timeout, bus.step_count, bus.done);
        end
    endtask
    task automatic test_halt();
        logic [2:0] p[$];
        int e_b, n = 0;
        for (int i = 0; i < 12; i++) p.push_back(3'd7);
        p.push_back(3'd1);
        load_prog(p);
        exp_q.push_back(8'd12);
        e_b = en_q.size();
        send_cmd(2'd1, 8'd0);
        while (!(bus.core_enable && bus.step_count == 16'd3) && n < 100) begin
            tick();
            n++;
        end
        if (n == 100) bound_fail("halt_exec");
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd3;
        tick();
        bus.cmd_valid = 1'b0;
        settle(20);
        checks++;
        if (bus.step_count !== 16'd4 || en_q.size() - e_b != 4 || {bus.busy, bus.done} !== 2'b00) begin
            failures++;
            $display("FAIL halt_pause: step=%0d enables=%0d busy,done=%b expected 4, 4, 00", bus.step_count, en_q.size() - e_b, {bus.busy, bus.done});
        end
        send_cmd(2'd1, 8'd0);
        settle(200);
        checks++;
        if (bus.done !== 1'b1 || bus.step_count !== 16'd13 || en_q.size() - e_b != 13) begin
            failures++;
            $display("FAIL halt_resume: done=%b step=%0d enables=%0d expected 1, 13, 13", bus.done, bus.step_count, en_q.size() - e_b);
        end
        checks++;
        if (rx_q.size() != rx_rd + 1 || rx_q[rx_rd] !== exp_q[0]) begin
            failures++;
            $display("FAIL halt_tx: got %0d bytes expected one %0h", rx_q.size() - rx_rd, exp_q[0]);
        end
        rx_rd = rx_q.size();
        void'(exp_q.pop_front());
    endtask
    task automatic test_len0();
        logic [2:0] p[$];
        int w_b = wa_q.size();
        int r_b = n_restart;
        load_prog(p);
        checks++;
        if (wa_q.size() != w_b || n_restart - r_b != 1 || {bus.busy, bus.done, bus.cmd_ready} !== 3'b001) begin
            failures++;
            $display("FAIL len0: writes=%0d restarts=%0d busy,done,ready=%b expected 0, 1, 001", wa_q.size() - w_b, n_restart - r_b, {bus.busy, bus.done, bus.cmd_ready});
        end
    endtask
    task automatic test_reset_mid();
        logic [2:0] p[$];
        int e_b, w_b, n = 0;
        w_b = wa_q.size();
        send_cmd(2'd0, 8'd5);
        for (int i = 0; i < 2; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_op    = 3'd7;
            tick();
        end
        bus.ld_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (wa_q.size() - w_b != 2 || {bus.busy, bus.done, bus.ld_ready, bus.core_enable, bus.tx_valid, bus.err_timeout} !== 6'd0 || bus.step_count !== 16'd0) begin
            failures++;
            $display("FAIL rst_load: writes=%0d flags=%b step=%0d expected 2, 000000, 0", wa_q.size() - w_b, {bus.busy, bus.done, bus.ld_ready, bus.core_enable, bus.tx_valid, bus.err_timeout}, bus.step_count);
        end
        e_b = en_q.size();
        send_cmd(2'd1, 8'd0);
        repeat (4) tick();
        checks++;
        if (en_q.size() != e_b || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL rst_load_run: enables=%0d busy=%b done=%b expected 0, 0, 0", en_q.size() - e_b, bus.busy, bus.done);
        end
        p = '{3'd7, 3'd7, 3'd1};
        bus.tx_ready = 1'b0;
        load_prog(p);
        send_cmd(2'd1, 8'd0);
        while (!bus.tx_valid && n < 50) begin
            tick();
            n++;
        end
        if (n == 50) bound_fail("rst_tx_valid");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.tx_ready = 1'b1;
        checks++;
        if ({bus.tx_valid, bus.busy, bus.done} !== 3'b000 || bus.tx_data !== 8'd0 || bus.step_count !== 16'd0) begin
            failures++;
            $display("FAIL rst_tx: valid,busy,done=%b data=%0h step=%0d expected 000, 0, 0", {bus.tx_valid, bus.busy, bus.done}, bus.tx_data, bus.step_count);
        end
        e_b = en_q.size();
        send_cmd(2'd1, 8'd0);
        repeat (4) tick();
        checks++;
        if (en_q.size() != e_b || rx_q.size() != rx_rd || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_tx_run: enables=%0d bytes=%0d busy=%b expected 0, 0, 0", en_q.size() - e_b, rx_q.size() - rx_rd, bus.busy);
        end
    endtask
    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_len   = 8'd0;
        bus.ld_valid  = 1'b0;
        bus.ld_op     = 3'd0;
        bus.tx_ready  = 1'b1;
        test_reset();
        test_run_basic();
        test_tx_stall();
        test_step();
        test_timeout();
        test_halt();
        test_len0();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required bench completion");
        $fatal(1, "time limit");
    end
endmodule
